// File: rtl/adc_window_peak.sv
// Windowed peak/clip detector for the two ZMOD ADC channels.
// Each window of 2^WINDOW_LOG2 valid samples yields per-channel peak |x| and clip count.
module adc_window_peak #(
    parameter int ZMOD_DATA_SIZE = 14,
    parameter int WINDOW_LOG2    = 10
) (
    input  logic                      i_sys_clock,
    input  logic                      i_reset,
    input  logic                      i_adc_init_done,
    input  logic                      i_enable,
    input  logic                      i_sample_valid,
    input  logic [ZMOD_DATA_SIZE-1:0] i_adc_data_ch1,
    input  logic [ZMOD_DATA_SIZE-1:0] i_adc_data_ch2,
    input  logic                      i_result_ready,
    output logic                      o_result_valid,
    output logic [ZMOD_DATA_SIZE-1:0] o_peak_ch1,
    output logic [ZMOD_DATA_SIZE-1:0] o_peak_ch2,
    output logic [WINDOW_LOG2:0]      o_clip_cnt_ch1,
    output logic [WINDOW_LOG2:0]      o_clip_cnt_ch2,
    output logic                      o_overrun,
    output logic                      o_busy
);

    localparam logic [ZMOD_DATA_SIZE-1:0] MAX_CODE = {1'b0, {(ZMOD_DATA_SIZE-1){1'b1}}};
    localparam logic [ZMOD_DATA_SIZE-1:0] MIN_CODE = {1'b1, {(ZMOD_DATA_SIZE-1){1'b0}}};
    localparam logic [ZMOD_DATA_SIZE-1:0] ONE_DATA = ZMOD_DATA_SIZE'(1);
    localparam logic [WINDOW_LOG2-1:0]    ONE_IDX  = WINDOW_LOG2'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                    r_state;
    logic                      r_busy;
    logic [WINDOW_LOG2-1:0]    r_index;
    logic [ZMOD_DATA_SIZE-1:0] r_peak_ch1;
    logic [ZMOD_DATA_SIZE-1:0] r_peak_ch2;
    logic [WINDOW_LOG2:0]      r_clip_ch1;
    logic [WINDOW_LOG2:0]      r_clip_ch2;
    logic                      r_result_valid;
    logic [ZMOD_DATA_SIZE-1:0] r_res_peak_ch1;
    logic [ZMOD_DATA_SIZE-1:0] r_res_peak_ch2;
    logic [WINDOW_LOG2:0]      r_res_clip_ch1;
    logic [WINDOW_LOG2:0]      r_res_clip_ch2;
    logic                      r_overrun;

    logic                      w_run;
    logic                      w_last_sample;
    logic                      w_window_end;
    logic [ZMOD_DATA_SIZE-1:0] w_abs_ch1;
    logic [ZMOD_DATA_SIZE-1:0] w_abs_ch2;
    logic                      w_clip_ch1;
    logic                      w_clip_ch2;
    logic [ZMOD_DATA_SIZE-1:0] w_peak_next_ch1;
    logic [ZMOD_DATA_SIZE-1:0] w_peak_next_ch2;
    logic [WINDOW_LOG2:0]      w_clip_next_ch1;
    logic [WINDOW_LOG2:0]      w_clip_next_ch2;

    // Negating the min code at full width yields 2^(N-1), which is exact as unsigned.
    assign w_abs_ch1 = i_adc_data_ch1[ZMOD_DATA_SIZE-1] ? (~i_adc_data_ch1 + ONE_DATA) : i_adc_data_ch1;
    assign w_abs_ch2 = i_adc_data_ch2[ZMOD_DATA_SIZE-1] ? (~i_adc_data_ch2 + ONE_DATA) : i_adc_data_ch2;

    assign w_clip_ch1 = (i_adc_data_ch1 == MAX_CODE) || (i_adc_data_ch1 == MIN_CODE);
    assign w_clip_ch2 = (i_adc_data_ch2 == MAX_CODE) || (i_adc_data_ch2 == MIN_CODE);

    assign w_peak_next_ch1 = (w_abs_ch1 > r_peak_ch1) ? w_abs_ch1 : r_peak_ch1;
    assign w_peak_next_ch2 = (w_abs_ch2 > r_peak_ch2) ? w_abs_ch2 : r_peak_ch2;
    assign w_clip_next_ch1 = r_clip_ch1 + {{WINDOW_LOG2{1'b0}}, w_clip_ch1};
    assign w_clip_next_ch2 = r_clip_ch2 + {{WINDOW_LOG2{1'b0}}, w_clip_ch2};

    assign w_run         = i_enable && i_adc_init_done;
    assign w_last_sample = i_sample_valid && (r_index == {WINDOW_LOG2{1'b1}});
    // An abort on the final sample wins: the window is discarded.
    assign w_window_end  = (r_state == ACCUM) && w_run && w_last_sample;

    always_ff @(posedge i_sys_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_index        <= '0;
            r_peak_ch1     <= '0;
            r_peak_ch2     <= '0;
            r_clip_ch1     <= '0;
            r_clip_ch2     <= '0;
            r_result_valid <= 1'b0;
            r_res_peak_ch1 <= '0;
            r_res_peak_ch2 <= '0;
            r_res_clip_ch1 <= '0;
            r_res_clip_ch2 <= '0;
            r_overrun      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_run) begin
                        r_state    <= ACCUM;
                        r_busy     <= 1'b1;
                        r_index    <= '0;
                        r_peak_ch1 <= '0;
                        r_peak_ch2 <= '0;
                        r_clip_ch1 <= '0;
                        r_clip_ch2 <= '0;
                    end
                end
                ACCUM: begin
                    if (!w_run) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_index    <= '0;
                        r_peak_ch1 <= '0;
                        r_peak_ch2 <= '0;
                        r_clip_ch1 <= '0;
                        r_clip_ch2 <= '0;
                    end else if (i_sample_valid) begin
                        r_index <= r_index + ONE_IDX;
                        if (w_last_sample) begin
                            r_res_peak_ch1 <= w_peak_next_ch1;
                            r_res_peak_ch2 <= w_peak_next_ch2;
                            r_res_clip_ch1 <= w_clip_next_ch1;
                            r_res_clip_ch2 <= w_clip_next_ch2;
                            r_peak_ch1     <= '0;
                            r_peak_ch2     <= '0;
                            r_clip_ch1     <= '0;
                            r_clip_ch2     <= '0;
                        end else begin
                            r_peak_ch1 <= w_peak_next_ch1;
                            r_peak_ch2 <= w_peak_next_ch2;
                            r_clip_ch1 <= w_clip_next_ch1;
                            r_clip_ch2 <= w_clip_next_ch2;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A new result always wins over a same-cycle accept; overrun only if nobody took the old one.
            if (w_window_end) begin
                r_result_valid <= 1'b1;
                if (r_result_valid && !i_result_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_result_valid && i_result_ready) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign o_result_valid = r_result_valid;
    assign o_peak_ch1     = r_res_peak_ch1;
    assign o_peak_ch2     = r_res_peak_ch2;
    assign o_clip_cnt_ch1 = r_res_clip_ch1;
    assign o_clip_cnt_ch2 = r_res_clip_ch2;
    assign o_overrun      = r_overrun;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_adc_window_peak.sv
// Self-checking bench for adc_window_peak (16-sample windows) against a queue-based model.
module tb_adc_window_peak;

    localparam int DW = 14;
    localparam int WL = 4;
    localparam int WIN = 1 << WL;

    logic          clk;
    logic          rstN;
    logic          init;
    logic          en;
    logic          sv;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          rdy;
    logic          resValid;
    logic [DW-1:0] peak1;
    logic [DW-1:0] peak2;
    logic [WL:0]   clip1;
    logic [WL:0]   clip2;
    logic          overrun;
    logic          busy;

    int total = 0;
    int bad   = 0;

    adc_window_peak #(.ZMOD_DATA_SIZE(DW), .WINDOW_LOG2(WL)) dut (
        .i_sys_clock    (clk),
        .i_reset        (rstN),
        .i_adc_init_done(init),
        .i_enable       (en),
        .i_sample_valid (sv),
        .i_adc_data_ch1 (d1),
        .i_adc_data_ch2 (d2),
        .i_result_ready (rdy),
        .o_result_valid (resValid),
        .o_peak_ch1     (peak1),
        .o_peak_ch2     (peak2),
        .o_clip_cnt_ch1 (clip1),
        .o_clip_cnt_ch2 (clip2),
        .o_overrun      (overrun),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: keep the samples of the open window and summarise them when it fills.
    bit mActive, mValid, mOverrun;
    int mPeak1, mPeak2, mClip1, mClip2;
    int q1[$];
    int q2[$];

    function automatic int absOf(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int isClip(input int x);
        return (x == 8191 || x == -8192) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mActive = 0; mValid = 0; mOverrun = 0;
            mPeak1 = 0; mPeak2 = 0; mClip1 = 0; mClip2 = 0;
            q1.delete(); q2.delete();
        end else begin
            bit winEnd;
            bit run;
            int p1, p2, c1, c2;
            winEnd = 0;
            run = en && init;
            p1 = 0; p2 = 0; c1 = 0; c2 = 0;
            if (!mActive) begin
                if (run) begin
                    mActive = 1;
                    q1.delete(); q2.delete();
                end
            end else if (!run) begin
                mActive = 0;
                q1.delete(); q2.delete();
            end else if (sv) begin
                q1.push_back(int'($signed(d1)));
                q2.push_back(int'($signed(d2)));
                if (q1.size() == WIN) begin
                    winEnd = 1;
                    foreach (q1[k]) begin
                        if (absOf(q1[k]) > p1) p1 = absOf(q1[k]);
                        if (absOf(q2[k]) > p2) p2 = absOf(q2[k]);
                        c1 += isClip(q1[k]);
                        c2 += isClip(q2[k]);
                    end
                    q1.delete(); q2.delete();
                end
            end
            if (winEnd) begin
                if (mValid && !rdy) mOverrun = 1;
                mValid = 1;
                mPeak1 = p1; mPeak2 = p2; mClip1 = c1; mClip2 = c2;
            end else if (mValid && rdy) begin
                mValid = 0;
            end
        end
    end

    // Compare every output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        checkOutput("result_valid", int'(resValid), int'(mValid));
        checkOutput("busy", int'(busy), int'(mActive));
        checkOutput("overrun", int'(overrun), int'(mOverrun));
        checkOutput("peak_ch1", int'(peak1), mPeak1);
        checkOutput("peak_ch2", int'(peak2), mPeak2);
        checkOutput("clip_ch1", int'(clip1), mClip1);
        checkOutput("clip_ch2", int'(clip2), mClip2);
    end

    task automatic applyStimulus(input bit e, input bit ini, input bit v, input int x1, input int x2, input bit r);
        @(negedge clk);
        #1;
        en = e; init = ini; sv = v; rdy = r;
        d1 = DW'(x1);
        d2 = DW'(x2);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rstN = 0; en = 0; init = 0; sv = 0; rdy = 0;
        @(negedge clk);
        #1;
        rstN = 1;
    endtask

    int pat[16] = '{0, 100, -300, 50, 7, -7, 200, -200, 299, -299, 1, 2, 3, 4, 5, 6};

    task automatic checkBasic(input string tag);
        checkOutput({tag, "_peak1"}, int'(peak1), 300);
        checkOutput({tag, "_clip1"}, int'(clip1), 0);
        checkOutput({tag, "_peak2"}, int'(peak2), 8192);
        checkOutput({tag, "_clip2"}, int'(clip2), 16);
        checkOutput({tag, "_valid"}, int'(resValid), 1);
    endtask

    initial begin
        rstN = 0; en = 0; init = 0; sv = 0; rdy = 0; d1 = '0; d2 = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_valid", int'(resValid), 0);
        checkOutput("rst_peak1", int'(peak1), 0);
        checkOutput("rst_clip2", int'(clip2), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        rstN = 1;

        // Init not done: valid samples must be ignored.
        for (int i = 0; i < 100; i++) applyStimulus(1, 0, 1, int'($urandom_range(0, 16383)), 8191, 0);
        settle();
        checkOutput("idle_valid", int'(resValid), 0);
        checkOutput("idle_busy", int'(busy), 0);

        // Basic window; the sample in the enabling cycle must not count.
        applyStimulus(1, 1, 1, 5000, 5000, 0);
        for (int i = 0; i < WIN; i++) applyStimulus(1, 1, 1, pat[i], -8192, 0);
        settle();
        checkBasic("basic");
        applyStimulus(1, 1, 0, 0, 0, 1);
        settle();
        checkOutput("accept_valid", int'(resValid), 0);

        // Gapped valid with garbage on the idle cycles.
        for (int i = 0; i < WIN; i++) begin
            applyStimulus(1, 1, 0, 8191, 8191, 0);
            applyStimulus(1, 1, 1, pat[i], -8192, 0);
        end
        settle();
        checkBasic("gapped");
        applyStimulus(1, 1, 0, 0, 0, 1);

        // Backpressure across two windows.
        for (int i = 0; i < WIN; i++) applyStimulus(1, 1, 1, (i == 5) ? 1000 : 10, 0, 0);
        for (int i = 0; i < WIN; i++) applyStimulus(1, 1, 1, (i == 9) ? -2000 : 20, 0, 0);
        settle();
        checkOutput("ovr_peak1", int'(peak1), 2000);
        checkOutput("ovr_flag", int'(overrun), 1);
        checkOutput("ovr_valid", int'(resValid), 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        settle();
        checkOutput("ovr_accept_valid", int'(resValid), 0);
        checkOutput("ovr_sticky", int'(overrun), 1);

        // Accept coinciding with window end.
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < WIN; i++) applyStimulus(1, 1, 1, 500, -500, 0);
        for (int i = 0; i < WIN; i++) applyStimulus(1, 1, 1, 600, 8191, i == WIN - 1);
        settle();
        checkOutput("coin_peak1", int'(peak1), 600);
        checkOutput("coin_clip2", int'(clip2), 16);
        checkOutput("coin_valid", int'(resValid), 1);
        checkOutput("coin_overrun", int'(overrun), 0);
        applyStimulus(1, 1, 0, 0, 0, 1);

        // Mid-window abort, then a clean window of tens.
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 1, 5000, 8191, 0);
        applyStimulus(0, 1, 1, 5000, 8191, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < WIN; i++) applyStimulus(1, 1, 1, 10, -10, 0);
        settle();
        checkOutput("abort_peak1", int'(peak1), 10);
        checkOutput("abort_clip1", int'(clip1), 0);
        checkOutput("abort_peak2", int'(peak2), 10);
        checkOutput("abort_valid", int'(resValid), 1);
        applyStimulus(1, 1, 0, 0, 0, 1);

        // Randomised traffic with full-scale codes weighted in.
        for (int i = 0; i < 3000; i++) begin
            int x1, x2, sel;
            sel = int'($urandom_range(0, 9));
            x1 = (sel == 0) ? 8191 : (sel == 1) ? -8192 : int'($urandom_range(0, 16383));
            sel = int'($urandom_range(0, 9));
            x2 = (sel == 0) ? 8191 : (sel == 1) ? -8192 : int'($urandom_range(0, 16383));
            applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 199) != 0,
                          $urandom_range(0, 3) != 0, x1, x2, $urandom_range(0, 2) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
